uart_tx_frame: RTL and testbench

- Parametrised UART transmitter, the successor to the fixed 8-bit transmitter.
- Configurable data width, parity mode and stop length (1, 1.5 or 2 bits).
- Valid/ready input handshake that allows back-to-back frames with no idle gap.
- Sits between a byte source (FIFO or CPU register) and the TX pad; one instance per serial channel.

---
 rtl/uart_tx_frame.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: valid/ready input, registered line output, optional parity and 1/1.5/2 stop bits.
// Define UART_TX_BREAK_EN to add the brk input that holds the line low while idle.
module uart_tx_frame #(
    parameter int FREQ        = 1_000_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_HALVES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 out,
    output logic                 busy
);

    localparam int HALF  = FREQ / (2 * BAUD);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx_frame: PARITY must be in 0..2");
    end
    if (STOP_HALVES < 2 || STOP_HALVES > 4) begin : g_chk_stop
        $error("uart_tx_frame: STOP_HALVES must be in 2..4");
    end
    if (HALF < 1) begin : g_chk_half
        $error("uart_tx_frame: FREQ/(2*BAUD) must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       half_cnt_q;
    logic [1:0]             half_num_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic                   out_d;
    logic                   brk_i;
    logic                   last_half;
    logic                   phase_done;
    logic                   last_bit;
    logic                   accept;
    logic [1:0]             phase_last_half;

`ifdef UART_TX_BREAK_EN
    assign brk_i = brk;
`else
    assign brk_i = 1'b0;
`endif

    // A phase is two half-bits, except STOP which lasts STOP_HALVES half-bits.
    assign phase_last_half = (state_q == S_STOP) ? 2'(STOP_HALVES - 1) : 2'd1;
    assign last_half       = (half_cnt_q == CNT_W'(HALF - 1));
    assign phase_done      = last_half && (half_num_q == phase_last_half);
    assign last_bit        = (bit_idx_q == IDX_W'(DATA_BITS - 1));

    assign ready  = ((state_q == S_IDLE) && !brk_i) || ((state_q == S_STOP) && phase_done);
    assign busy   = (state_q != S_IDLE);
    assign accept = valid && ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_START;
            S_START: if (phase_done) state_d = S_DATA;
            S_DATA:  if (phase_done && last_bit) state_d = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (phase_done) state_d = S_STOP;
            S_STOP:  if (phase_done) state_d = accept ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Line level for the next cycle, derived from the next state so the pad stays registered.
    always_comb begin
        out_d = 1'b1;
        unique case (state_d)
            S_IDLE:  out_d = !((state_q == S_IDLE) && brk_i);
            S_START: out_d = 1'b0;
            S_DATA:  out_d = ((state_q == S_DATA) && phase_done) ? shift_q[1] : shift_q[0];
            S_PAR:   out_d = parity_q;
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt_q <= '0;
            half_num_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            out        <= 1'b1;
        end else begin
            out <= out_d;
            if (accept) begin
                half_cnt_q <= '0;
                half_num_q <= '0;
                bit_idx_q  <= '0;
                shift_q    <= data;
                parity_q   <= (^data) ^ (PARITY == 2);
            end else if (state_q != S_IDLE) begin
                if (last_half) begin
                    half_cnt_q <= '0;
                    half_num_q <= phase_done ? 2'd0 : half_num_q + 2'd1;
                end else begin
                    half_cnt_q <= half_cnt_q + CNT_W'(1);
                end
                if (phase_done && (state_q == S_DATA)) begin
                    shift_q   <= shift_q >> 1;
                    bit_idx_q <= bit_idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at FREQ=8, BAUD=1 (HALF=4, 8 clocks per bit) across four configurations.
module tb_uart_tx_frame;

    logic       clk;
    logic       reset_n;
    logic       valid_v [4];
    logic [7:0] data_v  [4];
    logic       ready_v [4];
    logic       out_v   [4];
    logic       busy_v  [4];
`ifdef UART_TX_BREAK_EN
    logic       brk_v   [4];
`endif

    int total = 0;
    int bad   = 0;

    uart_tx_frame #(.FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_HALVES(2)) u_8n1 (
        .clk(clk), .reset_n(reset_n),
`ifdef UART_TX_BREAK_EN
        .brk(brk_v[0]),
`endif
        .data(data_v[0]), .valid(valid_v[0]), .ready(ready_v[0]), .out(out_v[0]), .busy(busy_v[0]));

    uart_tx_frame #(.FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_HALVES(2)) u_8e1 (
        .clk(clk), .reset_n(reset_n),
`ifdef UART_TX_BREAK_EN
        .brk(brk_v[1]),
`endif
        .data(data_v[1]), .valid(valid_v[1]), .ready(ready_v[1]), .out(out_v[1]), .busy(busy_v[1]));

    uart_tx_frame #(.FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_HALVES(2)) u_8o1 (
        .clk(clk), .reset_n(reset_n),
`ifdef UART_TX_BREAK_EN
        .brk(brk_v[2]),
`endif
        .data(data_v[2]), .valid(valid_v[2]), .ready(ready_v[2]), .out(out_v[2]), .busy(busy_v[2]));

    uart_tx_frame #(.FREQ(8), .BAUD(1), .DATA_BITS(7), .PARITY(0), .STOP_HALVES(3)) u_7n15 (
        .clk(clk), .reset_n(reset_n),
`ifdef UART_TX_BREAK_EN
        .brk(brk_v[3]),
`endif
        .data(data_v[3][6:0]), .valid(valid_v[3]), .ready(ready_v[3]), .out(out_v[3]), .busy(busy_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sends one frame and compares every clock of it against the hand-built bit sequence.
    // par < 0 means no parity bit; otherwise par[0] is the expected parity level.
    task automatic run_frame(input int which, input logic [7:0] d, input int nbits, input int par,
                             input int stop_clks, input bit raise_brk, input string tag);
        int         nseg;
        int         len;
        int         seg;
        int         ok [12];
        int         busy_cnt;
        int         rdy_early;
        logic       lvl;
        logic [7:0] sh;
        nseg      = 2 + nbits + ((par >= 0) ? 1 : 0);
        len       = 8 * (nseg - 1) + stop_clks;
        busy_cnt  = 0;
        rdy_early = 0;
        foreach (ok[i]) ok[i] = 0;
        @(negedge clk);
        check({tag, "_ready_idle"}, 32'(ready_v[which]), 32'd1);
        data_v[which]  = d;
        valid_v[which] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) valid_v[which] = 1'b0;
`ifdef UART_TX_BREAK_EN
            if (raise_brk && k == 10) brk_v[which] = 1'b1;
`else
            if (raise_brk && k == 10) $display("note: break requested without UART_TX_BREAK_EN");
`endif
            seg = k / 8;
            if (seg > nseg - 1) seg = nseg - 1;
            if (seg == 0) begin
                lvl = 1'b0;
            end else if (seg <= nbits) begin
                sh  = d >> (seg - 1);
                lvl = sh[0];
            end else if (par >= 0 && seg == nbits + 1) begin
                lvl = (par != 0);
            end else begin
                lvl = 1'b1;
            end
            if (out_v[which] === lvl) ok[seg]++;
            if (busy_v[which] === 1'b1) busy_cnt++;
            if (k < len - 1 && ready_v[which] !== 1'b0) rdy_early++;
            if (k == len - 1) check({tag, "_ready_last_stop"}, 32'(ready_v[which]), 32'd1);
        end
        for (int s = 0; s < nseg; s++)
            check($sformatf("%s_seg%0d", tag, s), 32'(ok[s]), (s == nseg - 1) ? 32'(stop_clks) : 32'd8);
        check({tag, "_busy_clks"}, 32'(busy_cnt), 32'(len));
        check({tag, "_ready_low"}, 32'(rdy_early), 32'd0);
        @(negedge clk);
        check({tag, "_idle_out"}, 32'(out_v[which]), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy_v[which]), 32'd0);
    endtask

    initial begin
        logic wave [161];
        int   acc;
        int   acc2_k;
        int   low_cnt;
        int   busy_cnt;

        reset_n = 1'b0;
        foreach (valid_v[i]) begin
            valid_v[i] = 1'b0;
            data_v[i]  = 8'h00;
`ifdef UART_TX_BREAK_EN
            brk_v[i]   = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        check("rst_out", 32'(out_v[0]), 32'd1);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_v[0]), 32'd1);
        check("post_rst_out_7n15", 32'(out_v[3]), 32'd1);

        run_frame(0, 8'hA5, 8, -1, 8, 1'b0, "8n1");
        run_frame(1, 8'hA5, 8, 0, 8, 1'b0, "8e1");
        run_frame(2, 8'hA5, 8, 1, 8, 1'b0, "8o1");
        run_frame(3, 8'h55, 7, -1, 12, 1'b0, "7n15");

        // Back-to-back: valid held high, data swapped to 0x80 just after the first accept.
        @(negedge clk);
        data_v[0]  = 8'h01;
        valid_v[0] = 1'b1;
        acc        = 0;
        acc2_k     = -1;
        for (int k = 0; k < 160; k++) begin
            if (k > 0) @(negedge clk);
            wave[k] = out_v[0];
            if (valid_v[0] && ready_v[0]) begin
                acc++;
                if (acc == 2) acc2_k = k;
            end
            if (k == 1) data_v[0] = 8'h80;
            if (acc == 2 && k == acc2_k + 1) valid_v[0] = 1'b0;
        end
        valid_v[0] = 1'b0;
        @(negedge clk);
        wave[160] = out_v[0];
        check("b2b_accepts", 32'(acc), 32'd2);
        check("b2b_second_accept_clk", 32'(acc2_k), 32'd80);
        check("b2b_f1_bit0", 32'(wave[12]), 32'd1);
        check("b2b_f1_bit1", 32'(wave[20]), 32'd0);
        check("b2b_f1_bit7", 32'(wave[72]), 32'd0);
        check("b2b_f1_last_stop", 32'(wave[80]), 32'd1);
        check("b2b_f2_start", 32'(wave[81]), 32'd0);
        check("b2b_f2_bit6", 32'(wave[140]), 32'd0);
        check("b2b_f2_bit7", 32'(wave[146]), 32'd1);
        check("b2b_f2_stop", 32'(wave[160]), 32'd1);
        repeat (5) @(negedge clk);
        check("b2b_idle_busy", 32'(busy_v[0]), 32'd0);

        // Reset in the middle of a 0x00 frame.
        @(negedge clk);
        data_v[0]  = 8'h00;
        valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (29) @(negedge clk);
        check("rst_mid_pre_out", 32'(out_v[0]), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_async_out", 32'(out_v[0]), 32'd1);
        check("rst_mid_async_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_mid_ready", 32'(ready_v[0]), 32'd1);
        low_cnt  = 0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_v[0] !== 1'b1) low_cnt++;
            if (busy_v[0] !== 1'b0) busy_cnt++;
        end
        check("rst_mid_no_low", 32'(low_cnt), 32'd0);
        check("rst_mid_no_busy", 32'(busy_cnt), 32'd0);

`ifdef UART_TX_BREAK_EN
        // Break raised mid-frame: frame finishes, then line held low until release.
        run_frame(0, 8'h0F, 8, -1, 8, 1'b1, "brk");
        @(negedge clk);
        check("brk_out_low", 32'(out_v[0]), 32'd0);
        check("brk_ready_low", 32'(ready_v[0]), 32'd0);
        check("brk_busy_low", 32'(busy_v[0]), 32'd0);
        repeat (3) @(negedge clk);
        check("brk_out_held", 32'(out_v[0]), 32'd0);
        brk_v[0] = 1'b0;
        #1;
        check("brk_rel_ready", 32'(ready_v[0]), 32'd1);
        @(negedge clk);
        check("brk_rel_out", 32'(out_v[0]), 32'd1);
        check("brk_rel_ready_next", 32'(ready_v[0]), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
